// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register between N requesters.
// Ports: clk, reset (sync, active-high); req[N], wdata[N*WIDTH] in;
// grant[N], ack[N], busy, owner[IDXW], q[WIDTH], qb[WIDTH] out.
module dff_share_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] wdata,
  output logic [N-1:0]       grant,
  output logic [N-1:0]       ack,
  output logic               busy,
  output logic [IDXW-1:0]    owner,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   qb
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACK
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDXW-1:0]   ptr;
  logic [IDXW-1:0]   winner;
  logic [IDXW-1:0]   pick_idx;
  logic              pick_valid;
  logic [WIDTH-1:0]  win_data;

  // (base + off) mod N, valid for base < N and off <= N.
  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N) s = s - N;
    return IDXW'(s);
  endfunction

  // First set request scanning upward from ptr with wrap.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      if (!pick_valid && req[wrap_add(ptr, off)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_add(ptr, off);
      end
    end
  end

  // wdata slice is taken from the registered winner, so it is sampled at the LOAD edge.
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (winner == IDXW'(i)) win_data = wdata[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = LOAD;
      LOAD:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == LOAD) || (state == ACK);
    ack  = (state == ACK) ? grant : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      winner <= '0;
      grant  <= '0;
      owner  <= '0;
      q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            winner <= pick_idx;
            grant  <= N'(1) << pick_idx;
          end
        end
        LOAD: begin
          q     <= win_data;
          owner <= winner;
        end
        ACK: begin
          ptr   <= wrap_add(winner, 1);
          grant <= '0;
        end
        default: ;
      endcase
    end
  end

  assign qb = ~q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
module tb_dff_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic [7:0]  qb;

  int total = 0;
  int bad   = 0;

  dff_share_arbiter #(.N(4), .WIDTH(8), .IDXW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
    .grant (grant),
    .ack   (ack),
    .busy  (busy),
    .owner (owner),
    .q     (q),
    .qb    (qb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1);
  end

  // Drives one full write from IDLE (called at a negedge) and records outputs.
  task automatic run_write(input  logic [3:0] r,
                           output logic [3:0] g_load,
                           output logic [7:0] q_ack,
                           output logic [1:0] own_ack,
                           output logic [3:0] ack_ack,
                           output logic [3:0] ack_after,
                           output logic [3:0] g_after);
    req = r;
    @(negedge clk);
    g_load = grant;
    @(negedge clk);
    q_ack   = q;
    own_ack = owner;
    ack_ack = ack;
    req     = '0;
    @(negedge clk);
    ack_after = ack;
    g_after   = grant;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (q !== 8'h00)   begin bad++; $display("FAIL reset_q got=%h exp=%h", q, 8'h00); end
    total++; if (qb !== 8'hFF)  begin bad++; $display("FAIL reset_qb got=%h exp=%h", qb, 8'hFF); end
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0); end
    total++; if (ack !== 4'b0)  begin bad++; $display("FAIL reset_ack got=%b exp=%b", ack, 4'b0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=%b", busy, 1'b0); end
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=%0d", owner, 0); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=%b", busy, 1'b0); end
  endtask

  task automatic test_single_write();
    wdata = 32'h00_A5_00_00;
    req   = 4'b0100;
    @(negedge clk);
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b exp=%b", grant, 4'b0100); end
    total++; if (busy !== 1'b1)     begin bad++; $display("FAIL single_busy got=%b exp=%b", busy, 1'b1); end
    total++; if (ack !== 4'b0)      begin bad++; $display("FAIL single_ack_load got=%b exp=%b", ack, 4'b0); end
    total++; if (q !== 8'h00)       begin bad++; $display("FAIL single_q_load got=%h exp=%h", q, 8'h00); end
    @(negedge clk);
    total++; if (q !== 8'hA5)       begin bad++; $display("FAIL single_q got=%h exp=%h", q, 8'hA5); end
    total++; if (qb !== 8'h5A)      begin bad++; $display("FAIL single_qb got=%h exp=%h", qb, 8'h5A); end
    total++; if (owner !== 2'd2)    begin bad++; $display("FAIL single_owner got=%0d exp=%0d", owner, 2); end
    total++; if (ack !== 4'b0100)   begin bad++; $display("FAIL single_ack got=%b exp=%b", ack, 4'b0100); end
    req = '0;
    @(negedge clk);
    total++; if (ack !== 4'b0)      begin bad++; $display("FAIL single_ack_once got=%b exp=%b", ack, 4'b0); end
    total++; if (grant !== 4'b0)    begin bad++; $display("FAIL single_grant_clr got=%b exp=%b", grant, 4'b0); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL single_busy_clr got=%b exp=%b", busy, 1'b0); end
    @(negedge clk);
    total++; if (q !== 8'hA5)       begin bad++; $display("FAIL single_q_hold got=%h exp=%h", q, 8'hA5); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h10; exp_q[1] = 8'h21; exp_q[2] = 8'h32; exp_q[3] = 8'h43;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wdata = 32'h43_32_21_10;
    req   = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      total++; if (grant !== (4'b0001 << (w % 4))) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", w, grant, 4'b0001 << (w % 4)); end
      @(negedge clk);
      total++; if (ack !== (4'b0001 << (w % 4))) begin bad++; $display("FAIL rr_ack[%0d] got=%b exp=%b", w, ack, 4'b0001 << (w % 4)); end
      total++; if (q !== exp_q[w % 4]) begin bad++; $display("FAIL rr_q[%0d] got=%h exp=%h", w, q, exp_q[w % 4]); end
      @(negedge clk);
      total++; if ((ack !== 4'b0) || (busy !== 1'b0)) begin bad++; $display("FAIL rr_idle[%0d] got ack=%b busy=%b exp ack=0000 busy=0", w, ack, busy); end
    end
    req = '0;
  endtask

  task automatic test_wrap();
    logic [3:0] g, a, a2, g2;
    logic [7:0] qv;
    logic [1:0] ow;
    wdata = 32'h43_32_21_10;
    // ptr is 1 here; lone requester 3 must still win.
    run_write(4'b1000, g, qv, ow, a, a2, g2);
    total++; if (g !== 4'b1000) begin bad++; $display("FAIL wrap_grant3 got=%b exp=%b", g, 4'b1000); end
    total++; if (qv !== 8'h43)  begin bad++; $display("FAIL wrap_q3 got=%h exp=%h", qv, 8'h43); end
    run_write(4'b0001, g, qv, ow, a, a2, g2);
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL wrap_grant0 got=%b exp=%b", g, 4'b0001); end
    total++; if (qv !== 8'h10)  begin bad++; $display("FAIL wrap_q0 got=%h exp=%h", qv, 8'h10); end
    total++; if (ow !== 2'd0)   begin bad++; $display("FAIL wrap_owner0 got=%0d exp=%0d", ow, 0); end
    total++; if (a !== 4'b0001 || a2 !== 4'b0 || g2 !== 4'b0) begin bad++; $display("FAIL wrap_ack0 got ack=%b after=%b grant_after=%b exp 0001/0000/0000", a, a2, g2); end
    // Winner 2 leaves ptr at 3; req[0] alone must wrap.
    run_write(4'b0100, g, qv, ow, a, a2, g2);
    run_write(4'b0001, g, qv, ow, a, a2, g2);
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL wrap_ptr3_grant got=%b exp=%b", g, 4'b0001); end
    total++; if (ow !== 2'd0)   begin bad++; $display("FAIL wrap_ptr3_owner got=%0d exp=%0d", ow, 0); end
    // ptr is 1; with 0 and 2 requesting, 2 is first scanning up from 1.
    run_write(4'b0101, g, qv, ow, a, a2, g2);
    total++; if (g !== 4'b0100) begin bad++; $display("FAIL wrap_prio_grant got=%b exp=%b", g, 4'b0100); end
    total++; if (qv !== 8'h32)  begin bad++; $display("FAIL wrap_prio_q got=%h exp=%h", qv, 8'h32); end
  endtask

  task automatic test_late_request();
    // ptr is 3 here.
    wdata = 32'h00_5E_3C_00;
    req   = 4'b0100;
    @(negedge clk);
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL late_grant2 got=%b exp=%b", grant, 4'b0100); end
    req = 4'b0110;
    @(negedge clk);
    total++; if (ack !== 4'b0100) begin bad++; $display("FAIL late_ack2 got=%b exp=%b", ack, 4'b0100); end
    total++; if (q !== 8'h5E)     begin bad++; $display("FAIL late_q2 got=%h exp=%h", q, 8'h5E); end
    req = 4'b0010;
    @(negedge clk);
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL late_idle got=%b exp=%b", grant, 4'b0000); end
    @(negedge clk);
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL late_grant1 got=%b exp=%b", grant, 4'b0010); end
    @(negedge clk);
    total++; if (ack !== 4'b0010) begin bad++; $display("FAIL late_ack1 got=%b exp=%b", ack, 4'b0010); end
    total++; if (q !== 8'h3C)     begin bad++; $display("FAIL late_q1 got=%h exp=%h", q, 8'h3C); end
    total++; if (owner !== 2'd1)  begin bad++; $display("FAIL late_owner1 got=%0d exp=%0d", owner, 1); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [3:0] g, a, a2, g2;
    logic [7:0] qv;
    logic [1:0] ow;
    logic       saw_ack;
    wdata = 32'h00_00_77_81;
    req   = 4'b0010;
    @(negedge clk);
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL mrst_grant_load got=%b exp=%b", grant, 4'b0010); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (q !== 8'h00)    begin bad++; $display("FAIL mrst_q got=%h exp=%h", q, 8'h00); end
    total++; if (qb !== 8'hFF)   begin bad++; $display("FAIL mrst_qb got=%h exp=%h", qb, 8'hFF); end
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL mrst_grant got=%b exp=%b", grant, 4'b0); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL mrst_busy got=%b exp=%b", busy, 1'b0); end
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL mrst_owner got=%0d exp=%0d", owner, 0); end
    reset = 1'b0;
    req   = '0;
    saw_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack !== 4'b0) saw_ack = 1'b1;
    end
    total++; if (saw_ack !== 1'b0) begin bad++; $display("FAIL mrst_no_ack got=%b exp=%b", saw_ack, 1'b0); end
    run_write(4'b0011, g, qv, ow, a, a2, g2);
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL mrst_next_grant got=%b exp=%b", g, 4'b0001); end
    total++; if (qv !== 8'h81)  begin bad++; $display("FAIL mrst_next_q got=%h exp=%h", qv, 8'h81); end
    // reset and request in the same cycle: reset wins.
    reset = 1'b1;
    req   = 4'b0100;
    @(negedge clk);
    total++; if (grant !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_req_same got grant=%b busy=%b exp grant=0000 busy=0", grant, busy); end
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    // ptr is 0; requester 1 holds req across its own ack.
    wdata = 32'h00_00_99_00;
    req   = 4'b0010;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      total++; if (grant !== 4'b0010) begin bad++; $display("FAIL b2b_grant[%0d] got=%b exp=%b", w, grant, 4'b0010); end
      @(negedge clk);
      total++; if (ack !== 4'b0010) begin bad++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", w, ack, 4'b0010); end
      total++; if (q !== 8'h99)     begin bad++; $display("FAIL b2b_q[%0d] got=%h exp=%h", w, q, 8'h99); end
      @(negedge clk);
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL b2b_idle[%0d] got=%b exp=%b", w, grant, 4'b0); end
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    wdata = '0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_round_robin();
    test_wrap();
    test_late_request();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
